// File: rtl/setup_tx.sv
// setup_tx: parallel-in, serial-out transmitter for the setup configuration path.
// A word is taken through a valid/ready handshake and shifted out LSB first,
// with en_out marking every presented bit.
// Optional feature: define SETUP_TX_PARITY_EN to send an even-parity bit
// ahead of the data bits.
module setup_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             serial_out,
  output logic             en_out,
  output logic             done_out
);

`ifdef SETUP_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_d;
  logic [NBITS-1:0] sr, sr_d, load_word;
  logic [CW-1:0]    cnt, cnt_d;
  logic             ser_d, en_d, done_d;

  // Parity, when enabled, sits in bit 0 so it leaves first; a WIDTH-bit
  // receiver then shifts it back out and ends holding the data word.
`ifdef SETUP_TX_PARITY_EN
  assign load_word = {data_in, ^data_in};
`else
  assign load_word = data_in;
`endif

  // Ready is a pure decode of state, forced low while reset is asserted.
  assign ready_out = (state == IDLE) && !rst_in;

  // Next-state and next-output decode. cnt counts bits already presented;
  // the edge that finds it at NBITS ends the burst and raises done.
  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    ser_d   = 1'b0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          state_d = SHIFT;
          sr_d    = load_word;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt == CW'(NBITS)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          ser_d = sr[0];
          en_d  = 1'b1;
          sr_d  = sr >> 1;
          cnt_d = cnt + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_d;
  end

  // Datapath and registered serial outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sr         <= '0;
      cnt        <= '0;
      serial_out <= 1'b0;
      en_out     <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      sr         <= sr_d;
      cnt        <= cnt_d;
      serial_out <= ser_d;
      en_out     <= en_d;
      done_out   <= done_d;
    end
  end

endmodule
